// File: rtl/data_mem_ctrl_pkg.sv
// mem_ctrl_pkg: size encodings, FSM states and alignment check shared by the data memory controller
package mem_ctrl_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, RESP} state_t;
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr);
        return (size == SZ_H && addr[0]) || (size == SZ_W && addr[1:0] != 2'b00) || (size == SZ_D && addr != 3'b000);
    endfunction
endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response handshake plus the Memoria32 port
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_wr;
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wr
    );
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wr
    );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: load lane select with sign/zero extension, and store lane merge into a word
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] oword_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] load_o,
    output logic [31:0] merge_o
);
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic        sign;
    // shift the addressed lane down for loads; place store data into the addressed lane of the old word
    always_comb begin
        shifted   = rword_i >> {off_i, 3'b000};
        sign      = !unsigned_i && (size_i == SZ_B ? shifted[7] : size_i == SZ_H ? shifted[15] : shifted[31]);
        load_o    = size_i == SZ_B ? {{56{sign}}, shifted[7:0]} :
                    size_i == SZ_H ? {{48{sign}}, shifted[15:0]} : {{32{sign}}, shifted};
        lane_mask = (size_i == SZ_B ? 32'h0000_00FF : 32'h0000_FFFF) << {off_i, 3'b000};
        merge_o   = (oword_i & ~lane_mask) | ((wdata_i << {off_i, 3'b000}) & lane_mask);
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: serves loads/stores against a 32-bit single-port memory, splitting dwords and doing RMW for sub-word stores
module data_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input logic            Clk,
    input logic            Reset,
    data_mem_ctrl_if.slave bus
);
    localparam int CW = $clog2(MEM_LAT + 1);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, uns_q, err_q, err_d, rd_done;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, lo_q, lo_d, lo_addr, merge_val;
    logic [63:0]   wdata_q, rdata_q, rdata_d, load_val;

    mem_lane_align u_align (
        .size_i    (size_q),
        .unsigned_i(uns_q),
        .off_i     (addr_q[1:0]),
        .rword_i   (bus.mem_rdata),
        .oword_i   (lo_q),
        .wdata_i   (wdata_q[31:0]),
        .load_o    (load_val),
        .merge_o   (merge_val)
    );

    // state, wait counter, captured word/response, and request fields latched on acceptance
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr[31:0];
                wdata_q <= bus.req_wdata;
            end
        end
    end

    // next state; RD states wait MEM_LAT cycles then capture, response registers load on entry to RESP
    always_comb begin
        rd_done = cnt_q == CW'(MEM_LAT);
        state_d = state_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = (state_q == RD_LO || state_q == RD_HI) && !rd_done ? cnt_q + 1'b1 : '0;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = misaligned(bus.req_size, bus.req_addr[2:0]) ? RESP :
                                                  bus.req_we && bus.req_size[1] ? WR_LO : RD_LO;
            RD_LO:   if (rd_done) begin
                         lo_d    = bus.mem_rdata;
                         state_d = we_q ? WR_LO : size_q == SZ_D ? RD_HI : RESP;
                     end
            RD_HI:   if (rd_done) state_d = RESP;
            WR_LO:   state_d = size_q == SZ_D ? WR_HI : RESP;
            WR_HI:   state_d = RESP;
            default: state_d = IDLE;
        endcase
        if (state_d == RESP && state_q != RESP) begin
            err_d   = state_q == IDLE;
            rdata_d = state_q == RD_HI ? {bus.mem_rdata, lo_q} : state_q == RD_LO ? load_val : '0;
        end
    end

    assign lo_addr       = {addr_q[31:2], 2'b00};
    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.mem_wr    = state_q == WR_LO || state_q == WR_HI;
    assign bus.mem_addr  = state_q == RD_HI || state_q == WR_HI ? lo_addr + 32'd4 :
                           state_q == RD_LO || state_q == WR_LO ? lo_addr : '0;
    assign bus.mem_wdata = state_q == WR_HI ? wdata_q[63:32] :
                           state_q == WR_LO ? (size_q[1] ? wdata_q[31:0] : merge_val) : '0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and randomized checks of data_mem_ctrl against a byte-level reference model
module tb_data_mem_ctrl;
    import mem_ctrl_pkg::*;
    localparam int L1 = 1;
    localparam int L3 = 3;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr   = 1'b1;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m1 [1024];
    logic [31:0] m3 [1024];
    logic [31:0] ref1 [1024];
    logic [31:0] p1;
    logic [31:0] p3 [3];

    always #5 clk = ~clk;

    data_mem_ctrl_if a ();
    data_mem_ctrl_if b ();
    data_mem_ctrl #(.MEM_LAT(L1)) dut1 (.Clk(clk), .Reset(rst_n), .bus(a.slave));
    data_mem_ctrl #(.MEM_LAT(L3)) dut3 (.Clk(clk), .Reset(rst_n), .bus(b.slave));

    // memories with MEM_LAT-deep read address pipelines
    assign a.mem_rdata = m1[p1[11:2]];
    assign b.mem_rdata = m3[p3[2][11:2]];
    always @(posedge clk) begin
        p1    <= a.mem_addr;
        p3[0] <= b.mem_addr;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        if (clr) begin
            for (int i = 0; i < 1024; i++) begin
                m1[i] <= '0;
                m3[i] <= '0;
            end
        end else begin
            if (a.mem_wr) m1[a.mem_addr[11:2]] <= a.mem_wdata;
            if (b.mem_wr) m3[b.mem_addr[11:2]] <= b.mem_wdata;
        end
    end

    function automatic logic [7:0] ref_byte(input int ad);
        return 8'(ref1[(ad >> 2) & 1023] >> (8 * (ad & 3)));
    endfunction

    function automatic logic [63:0] model_load(input logic [1:0] sz, input logic uns, input int ad);
        logic [63:0] v;
        int n;
        v = '0;
        n = 1 << sz;
        for (int i = 0; i < n; i++) v = v | (64'(ref_byte(ad + i)) << (8 * i));
        if (!uns && n < 8 && v[8 * n - 1]) v = v | ({64{1'b1}} << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input int ad, input logic [63:0] wd);
        for (int i = 0; i < (1 << sz); i++) begin
            int w;
            int l;
            w = ((ad + i) >> 2) & 1023;
            l = (ad + i) & 3;
            ref1[w][8 * l +: 8] = wd[8 * i +: 8];
        end
    endtask

    // one request on the MEM_LAT=1 instance, checked for latency, write beats, error and data
    task automatic run1(input logic we, input logic [1:0] sz, input logic uns, input logic [63:0] ad,
                        input logic [63:0] wd, input string tag);
        logic [63:0] exp_d;
        logic        mis;
        int          ia, exp_k, exp_w, k, wr;
        ia    = int'(ad[11:0]);
        mis   = (ia % (1 << sz)) != 0;
        exp_k = mis ? 0 : we ? (sz == SZ_D ? 2 : sz == SZ_W ? 1 : 2 + L1) : (sz == SZ_D ? 2 + 2 * L1 : 1 + L1);
        exp_w = (mis || !we) ? 0 : sz == SZ_D ? 2 : 1;
        exp_d = (mis || we) ? 64'd0 : model_load(sz, uns, ia);
        a.req_valid = 1'b1; a.req_we = we; a.req_size = sz; a.req_unsigned = uns;
        a.req_addr = ad; a.req_wdata = wd;
        total++;
        if (a.req_ready !== 1'b1) begin bad++; $display("FAIL %s ready got=%b exp=1", tag, a.req_ready); end
        @(posedge clk);
        #1;
        a.req_valid = 1'b0; a.req_we = 1'($urandom); a.req_size = 2'($urandom); a.req_unsigned = 1'($urandom);
        a.req_addr = {$urandom, $urandom}; a.req_wdata = {$urandom, $urandom};
        k = 0;
        wr = 0;
        while (k <= 40) begin
            @(negedge clk);
            if (a.rsp_valid) break;
            wr += int'(a.mem_wr);
            k++;
        end
        total++;
        if (k != exp_k) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", tag, k, exp_k); end
        if (k > 40) return;
        total++;
        if (wr != exp_w) begin bad++; $display("FAIL %s wr_beats got=%0d exp=%0d", tag, wr, exp_w); end
        total++;
        if (a.rsp_err !== mis) begin bad++; $display("FAIL %s err got=%b exp=%b", tag, a.rsp_err, mis); end
        total++;
        if (a.rsp_rdata !== exp_d) begin bad++; $display("FAIL %s rdata got=%h exp=%h", tag, a.rsp_rdata, exp_d); end
        if (!mis && we) model_store(sz, ia, wd);
        @(negedge clk);
    endtask

    task automatic check_mem(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 1024; i++) if (m1[i] !== ref1[i]) n++;
        total++;
        if (n != 0) begin bad++; $display("FAIL %s mem words_differing got=%0d exp=0", tag, n); end
    endtask

    task automatic test_reset();
        a.req_valid = 0; a.req_we = 0; a.req_size = 0; a.req_unsigned = 0; a.req_addr = 0; a.req_wdata = 0;
        b.req_valid = 0; b.req_we = 0; b.req_size = 0; b.req_unsigned = 0; b.req_addr = 0; b.req_wdata = 0;
        for (int i = 0; i < 1024; i++) ref1[i] = '0;
        repeat (3) @(negedge clk);
        clr   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (a.req_ready !== 1'b1) begin bad++; $display("FAIL reset ready got=%b exp=1", a.req_ready); end
        total++;
        if (a.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset rsp_valid got=%b exp=0", a.rsp_valid); end
        total++;
        if (a.rsp_rdata !== 64'd0) begin bad++; $display("FAIL reset rsp_rdata got=%h exp=0", a.rsp_rdata); end
        total++;
        if (a.rsp_err !== 1'b0) begin bad++; $display("FAIL reset rsp_err got=%b exp=0", a.rsp_err); end
        total++;
        if (a.mem_wr !== 1'b0) begin bad++; $display("FAIL reset mem_wr got=%b exp=0", a.mem_wr); end
        total++;
        if (a.mem_addr !== 32'd0) begin bad++; $display("FAIL reset mem_addr got=%h exp=0", a.mem_addr); end
        total++;
        if (a.mem_wdata !== 32'd0) begin bad++; $display("FAIL reset mem_wdata got=%h exp=0", a.mem_wdata); end
        total++;
        if (b.req_ready !== 1'b1) begin bad++; $display("FAIL reset ready_b got=%b exp=1", b.req_ready); end
    endtask

    task automatic test_plan();
        run1(1, SZ_W, 0, 64'h100, 64'h8000_00F0, "st_w100");
        run1(0, SZ_W, 0, 64'h100, 64'h0, "ld_w100");
        total++;
        if (a.rsp_rdata !== 64'hFFFF_FFFF_8000_00F0) begin bad++; $display("FAIL ld_w100 const got=%h exp=ffffffff800000f0", a.rsp_rdata); end
        run1(1, SZ_D, 0, 64'h200, 64'h1122_3344_5566_7788, "st_d200");
        total++;
        if (m1[128] !== 32'h5566_7788 || m1[129] !== 32'h1122_3344) begin
            bad++; $display("FAIL st_d200 words got=%h_%h exp=11223344_55667788", m1[129], m1[128]);
        end
        run1(1, SZ_W, 0, 64'h200, 64'h1122_3344, "st_w200");
        run1(1, SZ_B, 0, 64'h203, 64'hAB, "st_b203");
        total++;
        if (m1[128] !== 32'hAB22_3344) begin bad++; $display("FAIL st_b203 word got=%h exp=ab223344", m1[128]); end
        run1(1, SZ_W, 0, 64'h100, 64'h8765_4321, "st_w100b");
        run1(0, SZ_H, 1, 64'h102, 64'h0, "ld_hu102");
        total++;
        if (a.rsp_rdata !== 64'h8765) begin bad++; $display("FAIL ld_hu102 const got=%h exp=8765", a.rsp_rdata); end
        run1(0, SZ_H, 0, 64'h101, 64'h0, "ld_h101_mis");
        total++;
        if (a.rsp_err !== 1'b1 || a.rsp_rdata !== 64'd0) begin
            bad++; $display("FAIL ld_h101_mis err/rdata got=%b/%h exp=1/0", a.rsp_err, a.rsp_rdata);
        end
        run1(1, SZ_W, 0, 64'h1FE, 64'hDEAD_BEEF, "st_w1fe_mis");
        check_mem("plan");
    endtask

    task automatic test_reset_mid();
        logic seen;
        run1(1, SZ_D, 0, 64'h300, 64'hAAAA_0001_BBBB_0002, "st_d300_pre");
        a.req_valid = 1'b1; a.req_we = 1'b1; a.req_size = SZ_D; a.req_addr = 64'h300;
        a.req_wdata = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk);
        #1;
        a.req_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (a.mem_wr !== 1'b1) begin bad++; $display("FAIL rstmid wr_before got=%b exp=1", a.mem_wr); end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (a.mem_wr !== 1'b0) begin bad++; $display("FAIL rstmid wr_async got=%b exp=0", a.mem_wr); end
        total++;
        if (a.req_ready !== 1'b1) begin bad++; $display("FAIL rstmid ready got=%b exp=1", a.req_ready); end
        ref1[192] = 32'h9ABC_DEF0;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | a.rsp_valid;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rstmid rsp_valid got=%b exp=0", seen); end
        total++;
        if (m1[192] !== 32'h9ABC_DEF0 || m1[193] !== 32'hAAAA_0001) begin
            bad++; $display("FAIL rstmid words got=%h_%h exp=aaaa0001_9abcdef0", m1[193], m1[192]);
        end
        check_mem("rstmid");
    endtask

    task automatic test_random();
        logic        we, uns;
        logic [1:0]  sz;
        logic [63:0] ad, wd;
        for (int n = 0; n < 80; n++) begin
            we  = 1'($urandom);
            uns = 1'($urandom);
            sz  = 2'($urandom);
            ad  = {$urandom, $urandom};
            wd  = {$urandom, $urandom};
            if ($urandom_range(3) != 0) ad = ad & ~64'((1 << sz) - 1);
            run1(we, sz, uns, ad, wd, "rand");
        end
        for (int i = 0; i < 1024; i++) begin
            if (ref1[i] != 32'd0) begin
                run1(0, SZ_W, 1, 64'(i * 4), 64'd0, "rand_rdback");
                break;
            end
        end
        check_mem("rand");
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        int          k;
        v = {$urandom, $urandom};
        b.req_valid = 1'b1; b.req_we = 1'b1; b.req_size = SZ_D; b.req_addr = 64'h40; b.req_wdata = v;
        @(posedge clk);
        #1;
        b.req_valid = 1'b0;
        k = 0;
        while (k <= 40) begin
            @(negedge clk);
            if (b.rsp_valid) break;
            k++;
        end
        total++;
        if (k != 2) begin bad++; $display("FAIL b2b st_d latency got=%0d exp=2", k); end
        @(negedge clk);
        b.req_valid = 1'b1; b.req_we = 1'b0; b.req_size = SZ_D; b.req_unsigned = 1'b0; b.req_addr = 64'h40;
        @(posedge clk);
        k = 0;
        while (k <= 40) begin
            @(negedge clk);
            if (b.rsp_valid) break;
            b.req_we = 1'($urandom); b.req_size = 2'($urandom); b.req_unsigned = 1'($urandom);
            b.req_addr = {$urandom, $urandom}; b.req_wdata = {$urandom, $urandom};
            k++;
        end
        total++;
        if (k != 2 + 2 * L3) begin bad++; $display("FAIL b2b ld_d latency got=%0d exp=%0d", k, 2 + 2 * L3); end
        total++;
        if (b.rsp_rdata !== v) begin bad++; $display("FAIL b2b ld_d rdata got=%h exp=%h", b.rsp_rdata, v); end
        b.req_we = 1'b0; b.req_size = SZ_W; b.req_unsigned = 1'b1; b.req_addr = 64'h44;
        total++;
        if (b.req_ready !== 1'b0) begin bad++; $display("FAIL b2b ready_in_resp got=%b exp=0", b.req_ready); end
        @(negedge clk);
        total++;
        if (b.req_ready !== 1'b1) begin bad++; $display("FAIL b2b ready_after got=%b exp=1", b.req_ready); end
        @(posedge clk);
        #1;
        b.req_valid = 1'b0;
        k = 0;
        while (k <= 40) begin
            @(negedge clk);
            if (b.rsp_valid) break;
            k++;
        end
        total++;
        if (k != 1 + L3) begin bad++; $display("FAIL b2b ld_w latency got=%0d exp=%0d", k, 1 + L3); end
        total++;
        if (b.rsp_rdata !== {32'd0, v[63:32]}) begin bad++; $display("FAIL b2b ld_w rdata got=%h exp=%h", b.rsp_rdata, {32'd0, v[63:32]}); end
        total++;
        if (m3[16] !== v[31:0] || m3[17] !== v[63:32]) begin
            bad++; $display("FAIL b2b mem got=%h_%h exp=%h", m3[17], m3[16], v);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_plan();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
